// File: rtl/demux_pkg.sv
// Shared types and default widths for the 1-to-2 stream demultiplexer.
package demux_pkg;

  typedef enum logic {
    DEST0 = 1'b0,
    DEST1 = 1'b1
  } dest_e;

  localparam int DEMUX_W  = 8;
  localparam int DEMUX_CW = 8;

endpackage : demux_pkg

// File: rtl/demux_out_slot.sv
// One output slot of the demultiplexer: a one-word holding register with
// valid/ready handshake and a saturating count of words loaded into it.
module demux_out_slot #(
  parameter int W  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [W-1:0]  load_data,
  input  logic          ready,
  output logic          valid,
  output logic [W-1:0]  data,
  output logic [CW-1:0] cnt,
  output logic          can_accept
);

  logic          full;
  logic [W-1:0]  data_q;
  logic [CW-1:0] cnt_q;
  logic          drain;

  assign drain      = full && ready;
  assign can_accept = !full || ready;
  assign valid      = full;
  assign data       = data_q;
  assign cnt        = cnt_q;

  // A load in the same cycle as a drain wins, so the slot reloads and stays full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full   <= 1'b0;
      data_q <= '0;
    end else if (load) begin
      full   <= 1'b1;
      data_q <= load_data;
    end else if (drain) begin
      full   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load && (cnt_q != {CW{1'b1}})) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule : demux_out_slot

// File: rtl/demux_1to2_stream.sv
// Registered 1-to-2 stream demultiplexer: steers each accepted input word
// into one of two independently stalling output slots.
module demux_1to2_stream
  import demux_pkg::*;
#(
  parameter int W  = DEMUX_W,
  parameter int CW = DEMUX_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  in_data,
  input  logic          in_sel,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  out0_data,
  output logic          out0_valid,
  input  logic          out0_ready,
  output logic [W-1:0]  out1_data,
  output logic          out1_valid,
  input  logic          out1_ready,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1
);

  dest_e dest;
  logic  can0;
  logic  can1;
  logic  accept;
  logic  load0;
  logic  load1;

  // in_ready looks only at the selected slot so a stalled neighbour never blocks.
  assign dest     = dest_e'(in_sel);
  assign in_ready = rst_n && ((dest == DEST0) ? can0 : can1);
  assign accept   = in_valid && in_ready;
  assign load0    = accept && (dest == DEST0);
  assign load1    = accept && (dest == DEST1);

  demux_out_slot #(.W(W), .CW(CW)) u_slot0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load0),
    .load_data  (in_data),
    .ready      (out0_ready),
    .valid      (out0_valid),
    .data       (out0_data),
    .cnt        (cnt0),
    .can_accept (can0)
  );

  demux_out_slot #(.W(W), .CW(CW)) u_slot1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load1),
    .load_data  (in_data),
    .ready      (out1_ready),
    .valid      (out1_valid),
    .data       (out1_data),
    .cnt        (cnt1),
    .can_accept (can1)
  );

endmodule : demux_1to2_stream

// File: tb/tb_demux_1to2_stream.sv
// Bench for demux_1to2_stream: directed scenarios plus randomized traffic
// scored against per-output expected-word queues.
module tb_demux_1to2_stream;

  localparam int W  = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_sel = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  out0_data, out1_data;
  logic          out0_valid, out1_valid;
  logic          out0_ready = 1'b0;
  logic          out1_ready = 1'b0;
  logic [CW-1:0] cnt0, cnt1;

  logic          s_in_ready;
  logic [W-1:0]  s_out0_data, s_out1_data;
  logic          s_out0_valid, s_out1_valid;
  logic [1:0]    s_cnt0, s_cnt1;

  int checks = 0;
  int failures = 0;

  // Reference: each output is a queue of words accepted but not yet drained.
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  int           m_cnt0, m_cnt1;
  logic         acc0, acc1, drn0, drn1;

  always #5 clk = ~clk;

  demux_1to2_stream #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  demux_1to2_stream #(.W(W), .CW(2)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(s_in_ready),
    .out0_data(s_out0_data), .out0_valid(s_out0_valid), .out0_ready(out0_ready),
    .out1_data(s_out1_data), .out1_valid(s_out1_valid), .out1_ready(out1_ready),
    .cnt0(s_cnt0), .cnt1(s_cnt1)
  );

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_cnt0 = 0;
    m_cnt1 = 0;
  endtask

  task automatic set_inputs(input logic v, input logic s, input logic [W-1:0] d,
                            input logic r0, input logic r1);
    @(negedge clk);
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    #1;
    acc0 = rst_n && v && !s && (q0.size() == 0 || r0);
    acc1 = rst_n && v &&  s && (q1.size() == 0 || r1);
    drn0 = rst_n && q0.size() != 0 && r0;
    drn1 = rst_n && q1.size() != 0 && r1;
  endtask

  task automatic advance();
    @(posedge clk);
    if (drn0) void'(q0.pop_front());
    if (drn1) void'(q1.pop_front());
    if (acc0) begin
      q0.push_back(in_data);
      if (m_cnt0 < 255) m_cnt0++;
    end
    if (acc1) begin
      q1.push_back(in_data);
      if (m_cnt1 < 255) m_cnt1++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_ready: got %0b expected 0", in_ready); end
    checks++;
    if ({out0_valid, out1_valid, out0_data, out1_data, cnt0, cnt1} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got v0=%0b v1=%0b d0=%0h d1=%0h c0=%0d c1=%0d expected all 0",
               out0_valid, out1_valid, out0_data, out1_data, cnt0, cnt1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL release_in_ready: got %0b expected 1", in_ready); end
  endtask

  task automatic test_basic();
    set_inputs(1'b1, 1'b0, 8'hA5, 1'b1, 1'b1);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL basic_ready: got %0b expected 1", in_ready); end
    advance();
    set_inputs(1'b1, 1'b1, 8'h3C, 1'b1, 1'b1);
    checks++;
    if (out0_valid !== 1'b1 || out0_data !== 8'hA5) begin
      failures++; $display("[TB] FAIL basic_out0: got v=%0b d=%0h expected v=1 d=a5", out0_valid, out0_data);
    end
    advance();
    set_inputs(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    checks++;
    if (out1_valid !== 1'b1 || out1_data !== 8'h3C) begin
      failures++; $display("[TB] FAIL basic_out1: got v=%0b d=%0h expected v=1 d=3c", out1_valid, out1_data);
    end
    checks++;
    if (cnt0 !== 8'd1 || cnt1 !== 8'd1) begin
      failures++; $display("[TB] FAIL basic_counts: got cnt0=%0d cnt1=%0d expected 1 1", cnt0, cnt1);
    end
    advance();
  endtask

  task automatic test_backpressure();
    set_inputs(1'b1, 1'b0, 8'h11, 1'b0, 1'b1);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_first_ready: got %0b expected 1", in_ready); end
    advance();
    for (int i = 0; i < 2; i++) begin
      set_inputs(1'b1, 1'b0, 8'h22, 1'b0, 1'b1);
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_stall_ready: got %0b expected 0", in_ready); end
      checks++;
      if (out0_valid !== 1'b1 || out0_data !== 8'h11) begin
        failures++; $display("[TB] FAIL bp_hold: got v=%0b d=%0h expected v=1 d=11", out0_valid, out0_data);
      end
      advance();
    end
    set_inputs(1'b1, 1'b0, 8'h22, 1'b1, 1'b1);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_release_ready: got %0b expected 1", in_ready); end
    advance();
    set_inputs(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (out0_valid !== 1'b1 || out0_data !== 8'h22) begin
      failures++; $display("[TB] FAIL bp_reload: got v=%0b d=%0h expected v=1 d=22", out0_valid, out0_data);
    end
    advance();
  endtask

  task automatic test_independence();
    set_inputs(1'b1, 1'b1, 8'h77, 1'b0, 1'b1);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL indep_ready: got %0b expected 1", in_ready); end
    advance();
    set_inputs(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (out1_valid !== 1'b1 || out1_data !== 8'h77) begin
      failures++; $display("[TB] FAIL indep_out1: got v=%0b d=%0h expected v=1 d=77", out1_valid, out1_data);
    end
    checks++;
    if (out0_valid !== 1'b1 || out0_data !== 8'h22) begin
      failures++; $display("[TB] FAIL indep_out0_kept: got v=%0b d=%0h expected v=1 d=22", out0_valid, out0_data);
    end
    advance();
    set_inputs(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    advance();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words[16];
    do_reset();
    for (int i = 0; i < 16; i++) words[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) begin
      set_inputs(1'b1, 1'b1, words[i], 1'b1, 1'b1);
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready[%0d]: got %0b expected 1", i, in_ready); end
      if (i > 0) begin
        checks++;
        if (out1_valid !== 1'b1 || out1_data !== words[i-1]) begin
          failures++; $display("[TB] FAIL b2b_word[%0d]: got v=%0b d=%0h expected v=1 d=%0h", i-1, out1_valid, out1_data, words[i-1]);
        end
      end
      advance();
    end
    set_inputs(1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
    checks++;
    if (out1_valid !== 1'b1 || out1_data !== words[15]) begin
      failures++; $display("[TB] FAIL b2b_last: got v=%0b d=%0h expected v=1 d=%0h", out1_valid, out1_data, words[15]);
    end
    checks++;
    if (cnt1 !== 8'd16) begin failures++; $display("[TB] FAIL b2b_cnt1: got %0d expected 16", cnt1); end
    advance();
  endtask

  task automatic test_random();
    logic         pv, ps, last_acc, exp_rdy;
    logic [W-1:0] pd;
    pv = 1'b0; ps = 1'b0; pd = '0; last_acc = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!pv || last_acc) begin
        pv = 1'($urandom_range(0, 3) != 0);
        ps = 1'($urandom_range(0, 1));
        pd = 8'($urandom);
      end
      set_inputs(pv, ps, pd, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
      exp_rdy = ps ? (q1.size() == 0 || out1_ready) : (q0.size() == 0 || out0_ready);
      checks++;
      if (in_ready !== exp_rdy) begin failures++; $display("[TB] FAIL rnd_ready[%0d]: got %0b expected %0b", i, in_ready, exp_rdy); end
      checks++;
      if (out0_valid !== (q0.size() != 0) || out1_valid !== (q1.size() != 0)) begin
        failures++; $display("[TB] FAIL rnd_valid[%0d]: got %0b%0b expected %0b%0b", i, out0_valid, out1_valid, q0.size() != 0, q1.size() != 0);
      end
      if (q0.size() != 0) begin
        checks++;
        if (out0_data !== q0[0]) begin failures++; $display("[TB] FAIL rnd_data0[%0d]: got %0h expected %0h", i, out0_data, q0[0]); end
      end
      if (q1.size() != 0) begin
        checks++;
        if (out1_data !== q1[0]) begin failures++; $display("[TB] FAIL rnd_data1[%0d]: got %0h expected %0h", i, out1_data, q1[0]); end
      end
      last_acc = acc0 || acc1;
      advance();
    end
    set_inputs(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (cnt0 !== 8'(m_cnt0) || cnt1 !== 8'(m_cnt1)) begin
      failures++; $display("[TB] FAIL rnd_counts: got %0d %0d expected %0d %0d", cnt0, cnt1, m_cnt0, m_cnt1);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_inputs(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
    advance();
    set_inputs(1'b1, 1'b1, 8'h6B, 1'b0, 1'b0);
    advance();
    set_inputs(1'b1, 1'b0, 8'h99, 1'b0, 1'b0);
    checks++;
    if (out0_valid !== 1'b1 || out1_valid !== 1'b1) begin
      failures++; $display("[TB] FAIL mid_full: got %0b%0b expected 11", out0_valid, out1_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out0_valid, out1_valid, out0_data, out1_data, cnt0, cnt1, in_ready} !== '0) begin
      failures++;
      $display("[TB] FAIL mid_reset_clear: got v=%0b%0b d=%0h/%0h c=%0d/%0d rdy=%0b expected all 0",
               out0_valid, out1_valid, out0_data, out1_data, cnt0, cnt1, in_ready);
    end
    in_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out0_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL mid_release: got rdy=%0b v0=%0b expected 1 0", in_ready, out0_valid);
    end
  endtask

  task automatic test_saturation();
    logic [W-1:0] words[5];
    do_reset();
    for (int i = 0; i < 5; i++) words[i] = 8'($urandom);
    for (int i = 0; i < 5; i++) begin
      set_inputs(1'b1, 1'b0, words[i], 1'b1, 1'b1);
      if (i > 0) begin
        checks++;
        if (s_out0_valid !== 1'b1 || s_out0_data !== words[i-1]) begin
          failures++; $display("[TB] FAIL sat_word[%0d]: got v=%0b d=%0h expected v=1 d=%0h", i-1, s_out0_valid, s_out0_data, words[i-1]);
        end
        checks++;
        if (s_cnt0 !== 2'((i < 3) ? i : 3)) begin
          failures++; $display("[TB] FAIL sat_cnt[%0d]: got %0d expected %0d", i, s_cnt0, (i < 3) ? i : 3);
        end
      end
      advance();
    end
    set_inputs(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    checks++;
    if (s_out0_valid !== 1'b1 || s_out0_data !== words[4]) begin
      failures++; $display("[TB] FAIL sat_last: got v=%0b d=%0h expected v=1 d=%0h", s_out0_valid, s_out0_data, words[4]);
    end
    checks++;
    if (s_cnt0 !== 2'd3 || cnt0 !== 8'd5) begin
      failures++; $display("[TB] FAIL sat_final_cnt: got narrow=%0d wide=%0d expected 3 5", s_cnt0, cnt0);
    end
    advance();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_independence();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_demux_1to2_stream
